signal_time_tracker: RTL and testbench
======================================

// Module: signal_time_tracker
// PURPOSE
// - Records the counter timestamps at which a pipeline handshake signal (e.g. ex_ready) was asserted.
// - Answers "when, at or after time T, was the signal first high?"
// - Used by the stage trackers to back-date stage start/end times once trace data arrives late.
// - Sits beside each stage tracker. Driven by the shared free-running cycle counter.
// PARAMETERS
// - WIDTH  1  width of tracked_signal. A sample counts as "high" when any bit is 1.
// - DEPTH  8  number of timestamps retained in history. Must be a power of 2, at least 2.
// PORTS
// - clk               in   1       rising-edge clock
// - rst               in   1       asynchronous, active-low reset
// - counter           in   32      signed cycle counter (integer)
// - tracked_signal    in   WIDTH   signal being recorded
// - value_in          in   32      look-back distance in cycles (integer, >=0)
// - recalculate_time  in   1       query strobe
// - time_out[1:0]     out  2x32    [0] = query reference time, [1] = first high time at/after it, or -1
// BEHAVIOUR
// - Reset (rst low, async):
//   - history emptied; time_out[0] = 0, time_out[1] = 0.
//   - A reset during a query aborts it; outputs go to 0 immediately.
// - Recording: on each posedge with tracked_signal high, push the current counter into a ring of DEPTH entries.
//   - When full, overwrite the oldest entry; no stall, no error.
// - Query, zero latency:
//   - While recalculate_time = 1, time_out is computed combinationally.
//   - T = counter - value_in, 32-bit signed, wraps naturally.
//   - time_out[0] = T.
//   - time_out[1] = smallest stored timestamp t with t >= T, else -1.
//   - Stored means recorded at an earlier edge; the current cycle's sample is not yet in history.
// - Hold: at the posedge where recalculate_time = 1, time_out is registered and held until the next query.
//   - Back-to-back query cycles each re-evaluate.
// - Simultaneous record and query in one cycle: the query sees history before the push.
// - Empty history, or every entry older than T: time_out[1] = -1. Caller then polls tracked_signal live.
// - value_in = 0: T = counter; only entries equal to counter can match, so normally -1.
// - Ties, or several entries >= T: the earliest wins. Ring order equals time order, so scan oldest to newest.
// CONFIGURATION
// - SIGNAL_TIME_TRACKER_EDGE_ONLY_EN defined:
//   - Record only rising edges: high now and low at the previous edge. Previous-sample register resets low.
// - Undefined (default):
//   - Record every cycle the signal is high. A 3-cycle pulse stores 3 timestamps.
// STRUCTURE
// - Shared package ryuki_datatypes:
//   - typedef timestamp_t (signed 32-bit)
//   - localparam TS_NONE = -1
// - Sub-module timestamp_ring #(DEPTH):
//   - write pointer, count, storage array
//   - read-out of entry i counted from the oldest
// - Top level: query comparator scan over DEPTH entries, plus output hold registers.
// TESTING
// - Reset, no activity: time_out = {0,0}. Query at counter=20, value_in=5 -> {15,-1}.
// - Signal high at counter 10 only; query at counter 14, value_in=6 (T=8) -> {8,10}.
//   - Same history with value_in=2 (T=12) -> {12,-1}.
// - Signal high at counter 10,11,12 (default build); query at 15, value_in=4 (T=11) -> time_out[1]=11.
//   - EDGE_ONLY_EN build, same stimulus -> -1. Only 10 is recorded, and 10 < 11.
// - Overflow, DEPTH=8: signal high at counter 1..12; query at 13, value_in=13 (T=0) -> time_out[1]=5.
//   - Entries 1..4 were overwritten.
// - Signal high in the query cycle itself (counter 30, value_in=1) with empty history -> {29,-1}.
//   - Next query at 31, value_in=1 -> {30,30}.
// - Assert rst mid-run after 4 records: outputs 0 at once. A query after release -> time_out[1] = -1.

Source files
------------

// File: rtl/signal_time_tracker_pkg.sv
//------------------------------------------------------------------------------
// Module : ryuki_datatypes (package)
// Brief  : Shared timestamp type and the "no match" sentinel.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ryuki_datatypes;

  typedef logic signed [31:0] timestamp_t;

  localparam timestamp_t TS_NONE = -32'sd1;

endpackage

`default_nettype wire

// File: rtl/signal_time_tracker_ring.sv
//------------------------------------------------------------------------------
// Module : timestamp_ring
// Brief  : DEPTH-entry overwrite-on-full timestamp history, read oldest-first.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timestamp_ring
  import ryuki_datatypes::*;
#(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  timestamp_t               din,
  output logic [CW-1:0]            count,
  output timestamp_t [DEPTH-1:0]   entries
);

  timestamp_t        r_mem [DEPTH];
  logic [PW-1:0]     r_wp;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     w_oldest;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_count <= '0;
    end else if (push) begin
      r_wp <= r_wp + 1'b1;
      if (r_count != CW'(DEPTH)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Storage needs no reset: r_count alone marks which slots are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wp] <= din;
    end
  end

  // When full the low count bits are zero, so the oldest slot is the write slot.
  assign w_oldest = r_wp - r_count[PW-1:0];
  assign count    = r_count;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_rd
      assign entries[i] = r_mem[w_oldest + PW'(i)];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/signal_time_tracker.sv
//------------------------------------------------------------------------------
// Module : signal_time_tracker
// Brief  : Records cycle-counter timestamps of a handshake signal and answers
//          "first high time at/after counter - value_in". Optional build macro
//          SIGNAL_TIME_TRACKER_EDGE_ONLY_EN records rising edges only.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module signal_time_tracker
  import ryuki_datatypes::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  timestamp_t           counter,
  input  logic [WIDTH-1:0]     tracked_signal,
  input  timestamp_t           value_in,
  input  logic                 recalculate_time,
  output timestamp_t [1:0]     time_out
);

  logic                    w_high;
  logic                    w_push;
  logic [CW-1:0]           w_count;
  timestamp_t [DEPTH-1:0]  w_entries;
  timestamp_t              w_ref;
  timestamp_t              w_first;
  logic                    w_found;
  timestamp_t              r_hold_ref;
  timestamp_t              r_hold_first;

  assign w_high = |tracked_signal;

`ifdef SIGNAL_TIME_TRACKER_EDGE_ONLY_EN
  logic r_prev_high;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_high <= 1'b0;
    end else begin
      r_prev_high <= w_high;
    end
  end

  assign w_push = w_high & ~r_prev_high;
`else
  assign w_push = w_high;
`endif

  timestamp_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .din     (counter),
    .count   (w_count),
    .entries (w_entries)
  );

  assign w_ref = counter - value_in;

  // Ring order is time order, so the first hit scanning from the oldest is the earliest.
  always_comb begin
    w_found = 1'b0;
    w_first = TS_NONE;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_found && (CW'(i) < w_count) && ($signed(w_entries[i]) >= w_ref)) begin
        w_found = 1'b1;
        w_first = w_entries[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_ref   <= '0;
      r_hold_first <= '0;
    end else if (recalculate_time) begin
      r_hold_ref   <= w_ref;
      r_hold_first <= w_first;
    end
  end

  // Reset gates the live query path so an in-flight query reads 0 immediately.
  always_comb begin
    time_out[0] = r_hold_ref;
    time_out[1] = r_hold_first;
    if (!rst) begin
      time_out[0] = '0;
      time_out[1] = '0;
    end else if (recalculate_time) begin
      time_out[0] = w_ref;
      time_out[1] = w_first;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_signal_time_tracker.sv
//------------------------------------------------------------------------------
// Module : tb_signal_time_tracker
// Brief  : Self-checking bench for signal_time_tracker (table + scoreboard).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_signal_time_tracker;
  import ryuki_datatypes::*;

`ifdef SIGNAL_TIME_TRACKER_EDGE_ONLY_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic             clk;
  logic             rst;
  timestamp_t       counter;
  logic [0:0]       tracked_signal;
  timestamp_t       value_in;
  logic             recalculate_time;
  timestamp_t [1:0] time_out;

  signal_time_tracker #(
    .WIDTH (1),
    .DEPTH (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .counter          (counter),
    .tracked_signal   (tracked_signal),
    .value_in         (value_in),
    .recalculate_time (recalculate_time),
    .time_out         (time_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rec_lo;
    int rec_hi;
    int q_cnt;
    int val;
    int exp0;
    int exp1;
  } vec_t;

  typedef struct {
    int e0;
    int e1;
  } exp_t;

  vec_t vecs[9];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_out(input int e0, input int e1);
    exp_t e;
    e.e0 = e0;
    e.e1 = e1;
    exp_q.push_back(e);
  endtask

  task automatic check_out(input string name);
    exp_t e;
    int   a0;
    int   a1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got {%0d,%0d}", name, time_out[0], time_out[1]);
    end else begin
      e  = exp_q.pop_front();
      a0 = time_out[0];
      a1 = time_out[1];
      if (a0 != e.e0) begin
        errors++;
        $display("FAIL %s time_out[0]: got %0d expected %0d", name, a0, e.e0);
      end
      checks++;
      if (a1 != e.e1) begin
        errors++;
        $display("FAIL %s time_out[1]: got %0d expected %0d", name, a1, e.e1);
      end
    end
  endtask

  task automatic drive(input int c, input bit sig, input bit rq, input int v);
    @(negedge clk);
    counter          = c;
    tracked_signal   = sig;
    recalculate_time = rq;
    value_in         = v;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst              = 1'b0;
    recalculate_time = 1'b0;
    tracked_signal   = 1'b0;
    #2;
    expect_out(0, 0);
    check_out(name);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst              = 1'b0;
    counter          = 0;
    tracked_signal   = 1'b0;
    value_in         = 0;
    recalculate_time = 1'b0;

    vecs[0] = '{rec_lo: 1,  rec_hi: 0,  q_cnt: 20, val: 5,  exp0: 15, exp1: -1};
    vecs[1] = '{rec_lo: 10, rec_hi: 10, q_cnt: 14, val: 6,  exp0: 8,  exp1: 10};
    vecs[2] = '{rec_lo: 10, rec_hi: 10, q_cnt: 14, val: 2,  exp0: 12, exp1: -1};
    vecs[3] = '{rec_lo: 10, rec_hi: 12, q_cnt: 15, val: 4,  exp0: 11, exp1: EDGE ? -1 : 11};
    vecs[4] = '{rec_lo: 1,  rec_hi: 12, q_cnt: 13, val: 13, exp0: 0,  exp1: EDGE ? 1 : 5};
    vecs[5] = '{rec_lo: 10, rec_hi: 10, q_cnt: 11, val: 0,  exp0: 11, exp1: -1};
    vecs[6] = '{rec_lo: 5,  rec_hi: 7,  q_cnt: 20, val: 14, exp0: 6,  exp1: EDGE ? -1 : 6};
    vecs[7] = '{rec_lo: 3,  rec_hi: 6,  q_cnt: 10, val: 10, exp0: 0,  exp1: 3};
    vecs[8] = '{rec_lo: 1,  rec_hi: 1,  q_cnt: 2,  val: 5,  exp0: -3, exp1: 1};

    do_reset("reset");
    drive(3, 1'b0, 1'b0, 0);
    #3;
    expect_out(0, 0);
    check_out("idle_after_reset");

    for (int k = 0; k < 9; k++) begin
      do_reset($sformatf("vec%0d_reset", k));
      for (int c = vecs[k].rec_lo; c <= vecs[k].rec_hi; c++) begin
        drive(c, 1'b1, 1'b0, 0);
      end
      drive(vecs[k].q_cnt, 1'b0, 1'b1, vecs[k].val);
      expect_out(vecs[k].exp0, vecs[k].exp1);
      #3;
      check_out($sformatf("vec%0d_query", k));
      drive(vecs[k].q_cnt + 7, 1'b0, 1'b0, 99);
      expect_out(vecs[k].exp0, vecs[k].exp1);
      #3;
      check_out($sformatf("vec%0d_hold", k));
    end

    // Record in the query cycle itself, then back-to-back re-evaluation.
    do_reset("same_cycle_reset");
    drive(30, 1'b1, 1'b1, 1);
    expect_out(29, -1);
    #3;
    check_out("same_cycle_q1");
    drive(31, 1'b0, 1'b1, 1);
    expect_out(30, 30);
    #3;
    check_out("same_cycle_q2");

    // Reset asserted during an active query.
    do_reset("midrun_reset");
    for (int c = 40; c < 44; c++) begin
      drive(c, 1'b1, 1'b0, 0);
    end
    drive(44, 1'b0, 1'b1, 10);
    expect_out(34, 40);
    #3;
    check_out("midrun_query");
    rst = 1'b0;
    #1;
    expect_out(0, 0);
    check_out("midrun_abort");
    @(negedge clk);
    rst = 1'b1;
    drive(50, 1'b0, 1'b1, 1);
    expect_out(49, -1);
    #3;
    check_out("after_reset_query");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
